lcd_cmd_dispatcher: RTL



---
 rtl/lcd_cmd_dispatcher.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_dispatcher.sv
// rtl/lcd_cmd_dispatcher.sv - host opcode FIFO and paced command issue to the LCD controller
//
// Buffers 4-bit host opcodes and issues them one at a time on cmd/cmd_valid.
// Issue is paced by the controller's busy. Opcode 0 (write) waits for done
// and then pulses frame_done.
//
// Optional build macro: LCD_CMD_FILTER_EN
//   defined   - opcodes 12..15 are handshaken but dropped; err_illegal is set
//               and stays set until reset
//   undefined - all opcodes are buffered; err_illegal is tied to 0
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   host_cmd     opcode from host
//   host_valid   host offers host_cmd
//   host_ready   FIFO not full
//   cmd          opcode to controller (holds last issued value)
//   cmd_valid    one-cycle issue strobe
//   busy         controller busy
//   done         controller frame-written pulse
//   fifo_count   commands currently buffered
//   frame_done   one-cycle pulse after done for an issued opcode 0
//   err_illegal  sticky illegal-opcode flag
module lcd_cmd_dispatcher #(
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     frame_done,
    output logic                     err_illegal
);

    localparam int               AW         = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [3:0]       HOLD_INIT  = 4'(HOLDOFF - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAITB, WAITD} state_t;

    state_t          state, next_state;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [3:0]      hold_cnt;
    logic            accept, illegal, push, pop, hold_load, frame_set;

    assign host_ready = (fifo_count != FULL_COUNT);
    assign accept     = host_valid && host_ready;

`ifdef LCD_CMD_FILTER_EN
    assign illegal = (host_cmd[3:2] == 2'b11);
`else
    assign illegal = 1'b0;
`endif

    // Illegal opcodes complete the handshake but never reach storage.
    assign push = accept && !illegal;

    // Storage has no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        hold_load  = 1'b0;
        frame_set  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0 && !busy) next_state = ISSUE;
            end
            ISSUE: begin
                pop = 1'b1;
                if (mem[rd_ptr] == 4'd0) begin
                    next_state = WAITD;
                end else begin
                    next_state = HOLD;
                    hold_load  = 1'b1;
                end
            end
            HOLD: begin
                // busy is ignored while the controller reacts to the issue
                if (hold_cnt == 4'd0) next_state = WAITB;
            end
            WAITB: begin
                if (!busy) next_state = IDLE;
            end
            WAITD: begin
                if (done) begin
                    next_state = IDLE;
                    frame_set  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The issue strobe is registered from the ISSUE cycle, so it appears
    // the cycle after the head is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt   <= 4'd0;
            cmd        <= 4'd0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (hold_load) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == HOLD && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
            cmd_valid  <= pop;
            if (pop) cmd <= mem[rd_ptr];
            frame_done <= frame_set;
        end
    end

`ifdef LCD_CMD_FILTER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_illegal <= 1'b0;
        end else if (accept && illegal) begin
            err_illegal <= 1'b1;
        end
    end
`else
    assign err_illegal = 1'b0;
`endif

endmodule
